dense_layer_seq: RTL and testbench



---
 rtl/dense_pkg.sv | 46 ++++
 rtl/dense_layer_seq_if.sv | 31 +++
 rtl/mac_unit.sv | 34 +++
 rtl/dense_layer_seq.sv | 145 ++++++++++++++
 tb/tb_dense_layer_seq.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// Shared constants, state type and width helpers for the dense layer.
package dense_pkg;

  localparam int unsigned ACT_NONE = 0;
  localparam int unsigned ACT_RELU = 1;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StFin,
    StOut
  } dense_state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << k) < 64'(v)) r = k + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

  // Wide enough for N_IN full-scale products plus a shifted bias without overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n_in);
    return 2 * dw + clog2(n_in + 1) + 1;
  endfunction

  // Clamp a wide signed value into the signed dw-bit range.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Input/output handshakes and coefficient write port of the dense layer.
interface dense_layer_seq_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DW    = 8
);
  import dense_pkg::*;

  localparam int unsigned ADDR_W = idx_width(N_OUT * (N_IN + 1));

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*DW-1:0]      in_data;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DW-1:0]           wr_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*DW-1:0]     out_data;

  modport master (
    output in_valid, in_data, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mac_unit.sv
// Signed DW x DW multiply-accumulate with synchronous clear.
module mac_unit #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_q;

  // Full-precision signed product.
  always_comb begin
    prod = a * b;
  end

  // Accumulator: clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + AW'(prod);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared MAC walks every neuron's
// dot product, then rescales, saturates and activates into out_data.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned ACT   = 1
) (
  input logic             clk,
  input logic             rst,
  dense_layer_seq_if.slave bus
);

  localparam int unsigned NCOEF  = N_OUT * (N_IN + 1);
  localparam int unsigned ADDR_W = idx_width(NCOEF);
  localparam int unsigned IW     = idx_width(N_IN);
  localparam int unsigned JW     = idx_width(N_OUT);
  localparam int unsigned AW     = acc_width(DW, N_IN);

  dense_state_e          state_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic [N_IN*DW-1:0]    in_vec_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [N_OUT*DW-1:0]   out_data_q;

  // Weights and biases survive reset on purpose.
  logic [DW-1:0]         coef_mem [NCOEF];

  logic                  accept;
  logic                  mac_clr;
  logic                  mac_en;
  logic [ADDR_W-1:0]     w_addr;
  logic [ADDR_W-1:0]     b_addr;
  logic signed [DW-1:0]  x_cur;
  logic signed [DW-1:0]  w_cur;
  logic signed [DW-1:0]  b_cur;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  bias_ext;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  scaled;
  logic [DW-1:0]         res;

  assign accept  = (state_q == StIdle) && bus.in_valid;
  assign mac_clr = accept || (state_q == StFin);
  assign mac_en  = (state_q == StMac);

  // Coefficient writes only land while idle and inside the map.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == StIdle) && (32'(bus.wr_addr) < NCOEF)) begin
      coef_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Operand selection for the current (neuron, input) pair.
  always_comb begin
    w_addr = ADDR_W'(32'(j_q) * (N_IN + 1) + 32'(i_q));
    b_addr = ADDR_W'(32'(j_q) * (N_IN + 1) + N_IN);
    x_cur  = in_vec_q[32'(i_q) * DW +: DW];
    w_cur  = coef_mem[w_addr];
    b_cur  = coef_mem[b_addr];
  end

  mac_unit #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (x_cur),
    .b   (w_cur),
    .acc (acc)
  );

  // Bias align, floor-shift back to DW scale, saturate, then activation.
  always_comb begin
    bias_ext = {{(AW - DW){b_cur[DW-1]}}, b_cur};
    sum      = acc + (bias_ext <<< FRAC);
    scaled   = sum >>> FRAC;
    res      = DW'(sat_dw(64'(scaled), DW));
    if ((ACT == ACT_RELU) && res[DW-1]) res = '0;
  end

  // Sequencer: IDLE -> (MAC x N_IN -> FIN) x N_OUT -> OUT -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      in_vec_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            in_vec_q   <= bus.in_data;
            i_q        <= '0;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StMac;
          end
        end
        StMac: begin
          if (i_q == IW'(N_IN - 1)) begin
            state_q <= StFin;
          end else begin
            i_q <= i_q + IW'(1);
          end
        end
        StFin: begin
          out_data_q[32'(j_q) * DW +: DW] <= res;
          i_q <= '0;
          if (j_q == JW'(N_OUT - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            j_q     <= j_q + JW'(1);
            state_q <= StMac;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a ReLU instance and an identity instance run in
// lockstep on the same stimulus; expected values are hand-computed constants.
module tb_dense_layer_seq;
  import dense_pkg::*;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 4;
  localparam int unsigned DW     = 8;
  localparam int unsigned FRAC   = 4;
  localparam int unsigned ADDR_W = idx_width(N_OUT * (N_IN + 1));
  localparam int          NVEC   = 8;

  typedef struct packed {
    logic [3:0][7:0] x;
    logic [7:0]      wbase;  // w(j,i) = wbase + wsi*i + wsj*j
    logic [7:0]      wsi;
    logic [7:0]      wsj;
    logic [3:0][7:0] bias;
    logic [3:0][7:0] e1;     // expected, ReLU instance
    logic [3:0][7:0] e0;     // expected, identity instance
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus1 ();
  dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus0 ();

  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.in_data   = bus1.in_data;
  assign bus0.wr_en     = bus1.wr_en;
  assign bus0.wr_addr   = bus1.wr_addr;
  assign bus0.wr_data   = bus1.wr_data;
  assign bus0.out_ready = bus1.out_ready;

  dense_layer_seq #(
    .N_IN (N_IN), .N_OUT (N_OUT), .DW (DW), .FRAC (FRAC), .ACT (ACT_RELU)
  ) dut_relu (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dense_layer_seq #(
    .N_IN (N_IN), .N_OUT (N_OUT), .DW (DW), .FRAC (FRAC), .ACT (ACT_NONE)
  ) dut_lin (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    bus1.wr_en   = 1'b1;
    bus1.wr_addr = ADDR_W'(addr);
    bus1.wr_data = 8'(val);
    @(negedge clk);
    bus1.wr_en   = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        write_coef(j * 5 + i, int'($signed(v.wbase)) + int'($signed(v.wsi)) * i +
                   int'($signed(v.wsj)) * j);
      end
      write_coef(j * 5 + 4, int'($signed(v.bias[j])));
    end
  endtask

  // Accepts one vector, optionally disturbing the busy period or holding off
  // out_ready, then checks latency, both result vectors and the handshake.
  task automatic run_vec(input string name, input logic [3:0][7:0] x,
                         input logic [3:0][7:0] e1, input logic [3:0][7:0] e0,
                         input bit disturb, input int hold,
                         input int pre_addr, input int pre_data);
    int lat;
    logic [3:0][7:0] r1;
    logic [3:0][7:0] r0;
    chk($sformatf("%s in_ready_idle", name), 32'(bus1.in_ready), 32'd1);
    bus1.in_data   = x;
    bus1.in_valid  = 1'b1;
    bus1.out_ready = (hold == 0);
    if (pre_addr >= 0) begin
      bus1.wr_en   = 1'b1;
      bus1.wr_addr = ADDR_W'(pre_addr);
      bus1.wr_data = 8'(pre_data);
    end
    @(negedge clk);
    // lat counts cycles after the accept cycle
    lat = 1;
    while (bus1.out_valid !== 1'b1 && lat < 100) begin
      bus1.in_valid = disturb;
      bus1.in_data  = '0;
      bus1.wr_en    = disturb;
      bus1.wr_addr  = '0;
      bus1.wr_data  = '0;
      @(negedge clk);
      lat++;
    end
    bus1.in_valid = 1'b0;
    bus1.wr_en    = 1'b0;
    chk($sformatf("%s latency", name), 32'(lat), 32'd21);
    for (int k = 0; k < hold; k++) begin
      chk($sformatf("%s hold%0d out_valid", name, k), 32'(bus1.out_valid), 32'd1);
      chk($sformatf("%s hold%0d in_ready", name, k), 32'(bus1.in_ready), 32'd0);
      chk($sformatf("%s hold%0d out_data", name, k), bus1.out_data, e1);
      bus1.in_valid = 1'b1;
      bus1.in_data  = '1;
      @(negedge clk);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    r1 = bus1.out_data;
    r0 = bus0.out_data;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("%s relu n%0d", name, j), 32'(r1[j]), 32'(e1[j]));
      chk($sformatf("%s lin n%0d", name, j), 32'(r0[j]), 32'(e0[j]));
    end
    @(negedge clk);
    chk($sformatf("%s out_valid_drop", name), 32'(bus1.out_valid), 32'd0);
    chk($sformatf("%s lin out_valid_drop", name), 32'(bus0.out_valid), 32'd0);
    chk($sformatf("%s in_ready_back", name), 32'(bus1.in_ready), 32'd1);
    chk($sformatf("%s out_data_held", name), bus1.out_data, e1);
  endtask

  initial begin
    logic [3:0][7:0] x16;
    logic [3:0][7:0] e64;
    logic            seen;
    checks = 0;
    errors = 0;
    x16 = {4{8'h10}};
    e64 = {4{8'h40}};

    vecs[0] = '{x: {4{8'h10}}, wbase: 8'h10, wsi: 8'h00, wsj: 8'h00, bias: {4{8'h00}},
                e1: {4{8'h40}}, e0: {4{8'h40}}};
    vecs[1] = '{x: {4{8'h10}}, wbase: 8'h00, wsi: 8'h00, wsj: 8'h00,
                bias: {8'h40, 8'h30, 8'h20, 8'h10},
                e1: {8'h40, 8'h30, 8'h20, 8'h10}, e0: {8'h40, 8'h30, 8'h20, 8'h10}};
    vecs[2] = '{x: {4{8'h7F}}, wbase: 8'h7F, wsi: 8'h00, wsj: 8'h00, bias: {4{8'h7F}},
                e1: {4{8'h7F}}, e0: {4{8'h7F}}};
    vecs[3] = '{x: {4{8'h7F}}, wbase: 8'h80, wsi: 8'h00, wsj: 8'h00, bias: {4{8'h7F}},
                e1: {4{8'h00}}, e0: {4{8'h80}}};
    vecs[4] = '{x: {4{8'h10}}, wbase: 8'hF0, wsi: 8'h00, wsj: 8'h00, bias: {4{8'h00}},
                e1: {4{8'h00}}, e0: {4{8'hC0}}};
    // (55 - 16) >>> 4 = 2 ; (-55 - 16) >>> 4 = -5 (floor)
    vecs[5] = '{x: {8'h00, 8'h03, 8'hF8, 8'h10}, wbase: 8'h05, wsi: 8'h00, wsj: 8'h00,
                bias: {4{8'hFF}}, e1: {4{8'h02}}, e0: {4{8'h02}}};
    vecs[6] = '{x: {8'h00, 8'h03, 8'hF8, 8'h10}, wbase: 8'hFB, wsi: 8'h00, wsj: 8'h00,
                bias: {4{8'hFF}}, e1: {4{8'h00}}, e0: {4{8'hFB}}};
    // w(j,i) = 1 + i + 2j ; acc_j = 40*(1+2j) + 24 -> 64,144,224,304
    vecs[7] = '{x: {8'h08, 8'hF0, 8'h20, 8'h10}, wbase: 8'h01, wsi: 8'h01, wsj: 8'h02,
                bias: {4{8'h00}}, e1: {8'd19, 8'd14, 8'd9, 8'd4},
                e0: {8'd19, 8'd14, 8'd9, 8'd4}};

    rst            = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.wr_en     = 1'b0;
    bus1.wr_addr   = '0;
    bus1.wr_data   = '0;
    bus1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(bus1.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus1.out_valid), 32'd0);
    chk("reset out_data", bus1.out_data, 32'd0);
    chk("reset lin out_data", bus0.out_data, 32'd0);

    for (int v = 0; v < NVEC; v++) begin
      load(vecs[v]);
      run_vec($sformatf("vec%0d", v), vecs[v].x, vecs[v].e1, vecs[v].e0, 1'b0, 0, -1, 0);
    end

    // Backpressure with a stray in_valid during OUT.
    load(vecs[0]);
    run_vec("backpressure", x16, e64, e64, 1'b0, 10, -1, 0);

    // Writes and in_valid while busy must be ignored; weight 0 stays 16.
    run_vec("inflight", x16, e64, e64, 1'b1, 0, -1, 0);
    run_vec("after_inflight", x16, e64, e64, 1'b0, 0, -1, 0);

    // Reset on the 5th MAC cycle.
    bus1.in_data  = x16;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst in_ready", 32'(bus1.in_ready), 32'd1);
    chk("midrst out_valid", 32'(bus1.out_valid), 32'd0);
    chk("midrst out_data", bus1.out_data, 32'd0);
    chk("midrst lin out_data", bus0.out_data, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      seen = seen | bus1.out_valid | bus0.out_valid;
      @(negedge clk);
    end
    chk("midrst no partial out_valid", 32'(seen), 32'd0);
    run_vec("after_reset", x16, e64, e64, 1'b0, 0, -1, 0);

    // Write on the accept cycle reaches this computation: bias(0)=1.0 -> 5.0.
    run_vec("accept_write", x16, {8'h40, 8'h40, 8'h40, 8'h50}, {8'h40, 8'h40, 8'h40, 8'h50},
            1'b0, 0, 4, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
